gshare_spec_predictor: RTL and testbench
========================================

Name: gshare_spec_predictor

Overview:
- Next-generation fetch-stage branch predictor: gshare pattern history table (PHT) of parametrised saturating counters, plus an internal tagged direct-mapped BTB.
- Adds an internal speculative global history register (GHR) with per-lane history snapshots and single-cycle recovery on mispredict.
- Serves PREFETCH_DISTANCE fetch lanes per cycle; updated by the branch-resolve path.

Parameters:
PREFETCH_DISTANCE, 2, fetch lanes predicted per cycle
BHR_DEPTH, 8, GHR width in bits; must be <= PHT_IDX_BITS
PHT_IDX_BITS, 10, log2 of PHT entries
CTR_BITS, 2, saturating counter width (>=1)
BTB_IDX_BITS, 5, log2 of BTB entries

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
rd_valid  in  1  fetch bundle accepted this cycle; GHR advances only when high
rd_pcs  in  PREFETCH_DISTANCE x ADDR  lane PCs, lane 0 oldest
wr_en  in  1  resolved-branch update
wr_taken  in  1  resolved direction
wr_mispredict  in  1  resolved branch mispredicted; qualified by wr_en
wr_pc  in  ADDR  resolved branch PC
wr_target  in  ADDR  resolved target
wr_bhr  in  BHR_DEPTH  history snapshot carried with the branch (its pred_bhr)
pred_taken  out  PREFETCH_DISTANCE  per-lane taken prediction
pred_target  out  PREFETCH_DISTANCE x ADDR  per-lane target
pred_bhr  out  PREFETCH_DISTANCE x BHR_DEPTH  per-lane history snapshot
pred_is_branch  out  PREFETCH_DISTANCE  per-lane BTB hit

Behaviour:
- Reset (reset==0 at posedge): GHR=0; all BTB valid bits=0; every counter=2^(CTR_BITS-1)-1 (weakly not-taken). All outputs are combinational on state, so after reset they read 0 except pred_bhr, which reads 0 shifted as described below (also 0).
- BTB lookup: index=pc[2 +: BTB_IDX_BITS]; tag=remaining upper PC bits.
  - hit = valid && tag match.
  - pred_is_branch[i]=hit; pred_target[i]=stored target if hit, else 0.
- Lane history h_0=GHR; h_{i+1}=h_i<<1 if lane i hit, else h_i. pred_bhr[i]=h_i. The zero shifts in are correct because lanes after a taken lane are killed.
- PHT index for lane i: pc[2 +: PHT_IDX_BITS] XOR zero-extended h_i.
- pred_taken[i]=hit_i && counter MSB && no lane j<i predicted taken.
- Lanes after the first predicted-taken lane: pred_taken=0 and pred_is_branch=0; pred_target/pred_bhr are don't-care.
- Reads are combinational, zero latency. A same-cycle write is not visible to a read until the next cycle; no bypass.
- GHR next state, priority order:
  1. wr_en && wr_mispredict: GHR<={wr_bhr[BHR_DEPTH-2:0], wr_taken}. Any same-cycle rd_valid bundle is ignored (squashed by the frontend).
  2. Else if rd_valid: let k=last surviving lane with pred_is_branch. If k exists, GHR<={h_k[BHR_DEPTH-2:0], pred_taken[k]}; otherwise GHR unchanged.
  3. Else GHR holds.
- PHT update when wr_en: entry index = wr_pc[2 +: PHT_IDX_BITS] XOR wr_bhr. Saturating increment if wr_taken, else decrement. Saturates at 0 and 2^CTR_BITS-1.
- BTB update when wr_en && wr_taken: write valid, tag and target at wr_pc's index, overwriting any prior entry. Not-taken resolves never allocate or invalidate.
- Reset mid-operation overrides all writes in that cycle.

Optional Feature:
- Macro PRED_PERF_EN.
- When defined: add ports perf_lookups (out, 32) and perf_mispredicts (out, 32).
  - perf_lookups: +popcount(surviving pred_is_branch) per cycle with rd_valid and no recovery.
  - perf_mispredicts: +1 per wr_en && wr_mispredict.
  - Both reset to 0 and wrap at 2^32.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then lookup rd_pcs={0x100,0x104} -> pred_is_branch=00, pred_taken=00, pred_target=0, pred_bhr={0,0}; GHR stays 0 with rd_valid=1.
- Resolve wr_pc=0x100 taken to 0x200 with wr_bhr=0, twice (counter 1->2->3) -> with GHR=0, lookup 0x100 gives pred_is_branch=1, pred_taken=1, pred_target=0x200.
- Lanes 0x100 (hit, predicted not-taken) and 0x104 (hit, predicted taken), rd_valid=1, GHR=0x01 -> pred_bhr={0x01,0x02}; next GHR=0x05.
- Lane 0 predicted taken with lane 1 a BTB hit -> pred_taken=01, pred_is_branch[1]=0; GHR shifts once only.
- Same-cycle wr_mispredict (wr_bhr=0xA5, wr_taken=0) and rd_valid with hits -> GHR=0x4A next cycle; bundle history ignored.
- Saturation: 5 not-taken resolves on one entry -> counter stays 0; 5 taken resolves -> counter stays 3 (CTR_BITS=2); with PRED_PERF_EN, 3 mispredicts give perf_mispredicts=3.

Source files
------------

// File: rtl/gshare_spec_predictor.sv
// gshare_spec_predictor: multi-lane fetch-stage gshare predictor with a tagged
// direct-mapped BTB and a speculative global history register (GHR) that is
// advanced by accepted fetch bundles and repaired in one cycle on mispredict.
// Optional feature macro: PRED_PERF_EN adds perf_lookups / perf_mispredicts.

// Per-lane BTB hit detection and target gating.
module gshare_btb_lane #(
  parameter int TAG_W  = 25,
  parameter int ADDR_W = 32
) (
  input  logic              valid,
  input  logic [TAG_W-1:0]  entry_tag,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic [ADDR_W-1:0] entry_target,
  output logic              hit,
  output logic [ADDR_W-1:0] target
);
  assign hit    = valid && (entry_tag == lookup_tag);
  assign target = hit ? entry_target : '0;
endmodule

module gshare_spec_predictor #(
  parameter int PREFETCH_DISTANCE = 2,
  parameter int BHR_DEPTH         = 8,
  parameter int PHT_IDX_BITS      = 10,
  parameter int CTR_BITS          = 2,
  parameter int BTB_IDX_BITS      = 5,
  parameter int ADDR_W            = 32
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic                                           rd_valid,
  input  logic [PREFETCH_DISTANCE-1:0][ADDR_W-1:0]       rd_pcs,
  input  logic                                           wr_en,
  input  logic                                           wr_taken,
  input  logic                                           wr_mispredict,
  input  logic [ADDR_W-1:0]                              wr_pc,
  input  logic [ADDR_W-1:0]                              wr_target,
  input  logic [BHR_DEPTH-1:0]                           wr_bhr,
`ifdef PRED_PERF_EN
  output logic [31:0]                                    perf_lookups,
  output logic [31:0]                                    perf_mispredicts,
`endif
  output logic [PREFETCH_DISTANCE-1:0]                   pred_taken,
  output logic [PREFETCH_DISTANCE-1:0][ADDR_W-1:0]       pred_target,
  output logic [PREFETCH_DISTANCE-1:0][BHR_DEPTH-1:0]    pred_bhr,
  output logic [PREFETCH_DISTANCE-1:0]                   pred_is_branch
);
  localparam int NL          = PREFETCH_DISTANCE;
  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W       = ADDR_W - 2 - BTB_IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  logic [CTR_BITS-1:0]     pht        [PHT_ENTRIES];
  logic [BTB_ENTRIES-1:0]  btb_valid;
  logic [TAG_W-1:0]        btb_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0]       btb_target [BTB_ENTRIES];
  logic [BHR_DEPTH-1:0]    ghr;

  logic [NL-1:0]           lane_hit;
  logic                    last_vld;
  logic [BHR_DEPTH-1:0]    last_h;
  logic                    last_taken;
  logic [2*NL+1:0]         unused_pc_lsb;

  logic                    recover;
  logic [PHT_IDX_BITS-1:0] wr_idx;
  logic [BTB_IDX_BITS-1:0] wr_bidx;

  assign recover = wr_en && wr_mispredict;
  assign wr_idx  = wr_pc[2 +: PHT_IDX_BITS] ^ PHT_IDX_BITS'(wr_bhr);
  assign wr_bidx = wr_pc[2 +: BTB_IDX_BITS];
  assign unused_pc_lsb[2*NL +: 2] = wr_pc[1:0];

  // BTB lookups are history-independent, so each lane resolves its hit alone.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    logic [BTB_IDX_BITS-1:0] bidx;
    assign bidx = rd_pcs[g][2 +: BTB_IDX_BITS];
    assign unused_pc_lsb[2*g +: 2] = rd_pcs[g][1:0];
    gshare_btb_lane #(.TAG_W(TAG_W), .ADDR_W(ADDR_W)) u_lane (
      .valid        (btb_valid[bidx]),
      .entry_tag    (btb_tag[bidx]),
      .lookup_tag   (rd_pcs[g][ADDR_W-1 -: TAG_W]),
      .entry_target (btb_target[bidx]),
      .hit          (lane_hit[g]),
      .target       (pred_target[g])
    );
  end

  // Walk lanes oldest-first: chain history, index PHT, kill after first taken.
  always_comb begin
    logic [BHR_DEPTH-1:0]    h;
    logic [PHT_IDX_BITS-1:0] idx;
    logic                    seen_taken;
    logic                    raw_taken;
    h              = ghr;
    seen_taken     = 1'b0;
    last_vld       = 1'b0;
    last_h         = '0;
    last_taken     = 1'b0;
    pred_taken     = '0;
    pred_is_branch = '0;
    pred_bhr       = '0;
    for (int i = 0; i < NL; i++) begin
      pred_bhr[i] = h;
      idx         = rd_pcs[i][2 +: PHT_IDX_BITS] ^ PHT_IDX_BITS'(h);
      raw_taken   = lane_hit[i] && pht[idx][CTR_BITS-1];
      if (!seen_taken) begin
        pred_is_branch[i] = lane_hit[i];
        pred_taken[i]     = raw_taken;
        if (lane_hit[i]) begin
          last_vld   = 1'b1;
          last_h     = h;
          last_taken = raw_taken;
        end
        seen_taken = raw_taken;
      end
      if (lane_hit[i]) h = h << 1;
    end
  end

  // Speculative GHR: recovery beats bundle advance; idle holds.
  always_ff @(posedge clock) begin
    if (!reset)                   ghr <= '0;
    else if (recover)             ghr <= {wr_bhr[BHR_DEPTH-2:0], wr_taken};
    else if (rd_valid && last_vld) ghr <= {last_h[BHR_DEPTH-2:0], last_taken};
  end

  // PHT saturating counter training from the resolve path.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int e = 0; e < PHT_ENTRIES; e++) pht[e] <= CTR_INIT;
    end else if (wr_en) begin
      if (wr_taken && pht[wr_idx] != CTR_MAX)
        pht[wr_idx] <= pht[wr_idx] + CTR_BITS'(1);
      else if (!wr_taken && pht[wr_idx] != '0)
        pht[wr_idx] <= pht[wr_idx] - CTR_BITS'(1);
    end
  end

  // BTB valid bits; only taken resolves allocate.
  always_ff @(posedge clock) begin
    if (!reset)                 btb_valid <= '0;
    else if (wr_en && wr_taken) btb_valid[wr_bidx] <= 1'b1;
  end

  // BTB tag/target payload; meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (reset && wr_en && wr_taken) begin
      btb_tag[wr_bidx]    <= wr_pc[ADDR_W-1 -: TAG_W];
      btb_target[wr_bidx] <= wr_target;
    end
  end

`ifdef PRED_PERF_EN
  logic [31:0] lookup_inc;

  // Count surviving BTB hits in the current bundle.
  always_comb begin
    lookup_inc = '0;
    for (int i = 0; i < NL; i++) lookup_inc = lookup_inc + 32'(pred_is_branch[i]);
  end

  // Free-running wrap-around perf counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (rd_valid && !recover) perf_lookups <= perf_lookups + lookup_inc;
      if (recover)              perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor (default parameters).
module tb_gshare_spec_predictor;
  logic             clock = 1'b0;
  logic             reset;
  logic             rd_valid;
  logic [1:0][31:0] rd_pcs;
  logic             wr_en, wr_taken, wr_mispredict;
  logic [31:0]      wr_pc, wr_target;
  logic [7:0]       wr_bhr;
  logic [1:0]       pred_taken, pred_is_branch;
  logic [1:0][31:0] pred_target;
  logic [1:0][7:0]  pred_bhr;
`ifdef PRED_PERF_EN
  logic [31:0]      perf_lookups, perf_mispredicts;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  gshare_spec_predictor dut (
    .clock(clock), .reset(reset), .rd_valid(rd_valid), .rd_pcs(rd_pcs),
    .wr_en(wr_en), .wr_taken(wr_taken), .wr_mispredict(wr_mispredict),
    .wr_pc(wr_pc), .wr_target(wr_target), .wr_bhr(wr_bhr),
`ifdef PRED_PERF_EN
    .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts),
`endif
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_bhr(pred_bhr), .pred_is_branch(pred_is_branch)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [7:0] bhr, input logic tk, input logic mp);
    wr_en = 1'b1; wr_pc = pc; wr_target = tgt; wr_bhr = bhr;
    wr_taken = tk; wr_mispredict = mp;
    tick();
    wr_en = 1'b0; wr_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rd_valid = 1'b0; wr_en = 1'b0; wr_taken = 1'b0;
    wr_mispredict = 1'b0; wr_pc = '0; wr_target = '0; wr_bhr = '0;
    rd_pcs[0] = 32'h100; rd_pcs[1] = 32'h104;
    tick(); tick();
    reset = 1'b1; rd_valid = 1'b1;
    #1;
    checks++; if (pred_is_branch !== 2'b00) begin failures++; $display("FAIL reset_is_branch got=%b exp=00", pred_is_branch); end
    checks++; if (pred_taken !== 2'b00) begin failures++; $display("FAIL reset_taken got=%b exp=00", pred_taken); end
    checks++; if (pred_target !== 64'h0) begin failures++; $display("FAIL reset_target got=%h exp=0", pred_target); end
    checks++; if (pred_bhr !== 16'h0) begin failures++; $display("FAIL reset_bhr got=%h exp=0", pred_bhr); end
    tick();
    rd_valid = 1'b0;
    #1;
    checks++; if (pred_bhr[0] !== 8'h00) begin failures++; $display("FAIL reset_ghr_hold got=%h exp=00", pred_bhr[0]); end
  endtask

  task automatic test_train();
    rd_pcs[0] = 32'h100; rd_pcs[1] = 32'h300;
    wr_en = 1'b1; wr_pc = 32'h100; wr_target = 32'h200; wr_bhr = 8'h00; wr_taken = 1'b1;
    #1;
    checks++; if (pred_is_branch !== 2'b00) begin failures++; $display("FAIL no_bypass got=%b exp=00", pred_is_branch); end
    tick();
    resolve(32'h100, 32'h200, 8'h00, 1'b1, 1'b0);
    checks++; if (pred_is_branch !== 2'b01) begin failures++; $display("FAIL train_is_branch got=%b exp=01", pred_is_branch); end
    checks++; if (pred_taken !== 2'b01) begin failures++; $display("FAIL train_taken got=%b exp=01", pred_taken); end
    checks++; if (pred_target[0] !== 32'h200) begin failures++; $display("FAIL train_target got=%h exp=200", pred_target[0]); end
  endtask

  task automatic test_lane_history();
    resolve(32'h104, 32'h400, 8'h02, 1'b1, 1'b0);
    resolve(32'h104, 32'h400, 8'h02, 1'b1, 1'b0);
    resolve(32'h810, 32'h900, 8'h00, 1'b1, 1'b1);
    checks++; if (pred_bhr[0] !== 8'h01) begin failures++; $display("FAIL recover_set got=%h exp=01", pred_bhr[0]); end
    rd_pcs[0] = 32'h100; rd_pcs[1] = 32'h104; rd_valid = 1'b1;
    #1;
    checks++; if (pred_is_branch !== 2'b11) begin failures++; $display("FAIL hist_is_branch got=%b exp=11", pred_is_branch); end
    checks++; if (pred_taken !== 2'b10) begin failures++; $display("FAIL hist_taken got=%b exp=10", pred_taken); end
    checks++; if (pred_bhr[1] !== 8'h02) begin failures++; $display("FAIL hist_bhr1 got=%h exp=02", pred_bhr[1]); end
    checks++; if (pred_target[1] !== 32'h400) begin failures++; $display("FAIL hist_target1 got=%h exp=400", pred_target[1]); end
    tick();
    rd_valid = 1'b0;
    #1;
    checks++; if (pred_bhr[0] !== 8'h05) begin failures++; $display("FAIL hist_next_ghr got=%h exp=05", pred_bhr[0]); end
  endtask

  task automatic test_kill();
    resolve(32'h810, 32'h900, 8'h00, 1'b0, 1'b1);
    checks++; if (pred_bhr[0] !== 8'h00) begin failures++; $display("FAIL kill_ghr0 got=%h exp=00", pred_bhr[0]); end
    rd_pcs[0] = 32'h100; rd_pcs[1] = 32'h104; rd_valid = 1'b1;
    #1;
    checks++; if (pred_taken !== 2'b01) begin failures++; $display("FAIL kill_taken got=%b exp=01", pred_taken); end
    checks++; if (pred_is_branch !== 2'b01) begin failures++; $display("FAIL kill_is_branch got=%b exp=01", pred_is_branch); end
    tick();
    rd_valid = 1'b0;
    #1;
    checks++; if (pred_bhr[0] !== 8'h01) begin failures++; $display("FAIL kill_next_ghr got=%h exp=01", pred_bhr[0]); end
  endtask

  task automatic test_recovery();
    rd_pcs[0] = 32'h104; rd_pcs[1] = 32'h100; rd_valid = 1'b1;
    resolve(32'h810, 32'h900, 8'hA5, 1'b0, 1'b1);
    rd_valid = 1'b0;
    #1;
    checks++; if (pred_bhr[0] !== 8'h4A) begin failures++; $display("FAIL recovery_ghr got=%h exp=4a", pred_bhr[0]); end
  endtask

  task automatic test_saturation();
    // GHR=0x4A; lane 0 PC 0x100 reads PHT[0x40^0x4A], trained with wr_bhr=0x4A.
    rd_pcs[0] = 32'h100; rd_pcs[1] = 32'h300;
    for (int n = 0; n < 6; n++) resolve(32'h100, 32'h200, 8'h4A, 1'b0, 1'b0);
    checks++; if (pred_is_branch[0] !== 1'b1) begin failures++; $display("FAIL sat_btb_kept got=%b exp=1", pred_is_branch[0]); end
    checks++; if (pred_taken[0] !== 1'b0) begin failures++; $display("FAIL sat_floor got=%b exp=0", pred_taken[0]); end
    resolve(32'h100, 32'h200, 8'h4A, 1'b1, 1'b0);
    checks++; if (pred_taken[0] !== 1'b0) begin failures++; $display("FAIL sat_floor_plus1 got=%b exp=0", pred_taken[0]); end
    resolve(32'h100, 32'h200, 8'h4A, 1'b1, 1'b0);
    checks++; if (pred_taken[0] !== 1'b1) begin failures++; $display("FAIL sat_floor_plus2 got=%b exp=1", pred_taken[0]); end
    for (int n = 0; n < 4; n++) resolve(32'h100, 32'h200, 8'h4A, 1'b1, 1'b0);
    resolve(32'h100, 32'h200, 8'h4A, 1'b0, 1'b0);
    checks++; if (pred_taken[0] !== 1'b1) begin failures++; $display("FAIL sat_ceil_minus1 got=%b exp=1", pred_taken[0]); end
    resolve(32'h100, 32'h200, 8'h4A, 1'b0, 1'b0);
    checks++; if (pred_taken[0] !== 1'b0) begin failures++; $display("FAIL sat_ceil_minus2 got=%b exp=0", pred_taken[0]); end
    checks++; if (pred_target[0] !== 32'h200) begin failures++; $display("FAIL sat_target got=%h exp=200", pred_target[0]); end
  endtask

`ifdef PRED_PERF_EN
  task automatic test_perf();
    checks++; if (perf_mispredicts !== 32'd3) begin failures++; $display("FAIL perf_mispredicts got=%0d exp=3", perf_mispredicts); end
    checks++; if (perf_lookups !== 32'd3) begin failures++; $display("FAIL perf_lookups got=%0d exp=3", perf_lookups); end
  endtask
`endif

  initial begin
    test_reset();
    test_train();
    test_lane_history();
    test_kill();
    test_recovery();
    test_saturation();
`ifdef PRED_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
